// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the
// MEM-stage data port of the core.
//
// Ports:
//   clk, reset        rising-edge clock, async active-low reset
//   if_req/if_addr    fetch request (PCF); if_kill drops it on redirect
//   if_rdata/if_valid registered instruction and its one-cycle pulse
//   d_req/d_we/...    data request (ALUResultM, writeDataM, memWriteM,
//                     memTypeM), held until d_valid
//   d_rdata/d_valid   registered load data and its completion pulse
//   if_stall/d_stall  per-port pipeline freeze requests
//   mem_*             registered request to memory; mem_ack completes it
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int INSTR_W    = 32,
  parameter int MTYPE_W    = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic               if_kill,
  output logic [INSTR_W-1:0] if_rdata,
  output logic               if_valid,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [MTYPE_W-1:0] d_type,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               d_valid,
  output logic               if_stall,
  output logic               d_stall,
  output logic               mem_req,
  output logic               mem_we,
  output logic [MTYPE_W-1:0] mem_type,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    IFETCH,
    DACCESS
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t state;
  state_t state_nxt;

  logic [3:0]         starve_cnt;
  logic [3:0]         starve_nxt;
  logic               killed;
  logic               killed_nxt;
  logic               mem_req_nxt;
  logic               mem_we_nxt;
  logic [MTYPE_W-1:0] mem_type_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [DATA_W-1:0]  mem_wdata_nxt;
  logic [INSTR_W-1:0] if_rdata_nxt;
  logic               if_valid_nxt;
  logic [DATA_W-1:0]  d_rdata_nxt;
  logic               d_valid_nxt;

  logic fetch_ok;
  logic data_wins;
  logic grant_d;
  logic grant_f;

  assign fetch_ok  = if_req & ~if_kill;
  assign data_wins = d_req &
                     ((starve_cnt < SMAX) | ~fetch_ok);

  // A port whose valid pulse is up still shows its old
  // request; it must not be granted again. If that port
  // would win arbitration anyway, the cycle is a bubble.
  assign grant_d = (state == IDLE) & data_wins & ~d_valid;
  assign grant_f = (state == IDLE) & ~data_wins &
                   fetch_ok & ~if_valid;

  assign if_stall = if_req & ~if_valid & ~if_kill;
  assign d_stall  = d_req & ~d_valid;

  always_comb begin
    state_nxt     = state;
    starve_nxt    = starve_cnt;
    killed_nxt    = killed;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_type_nxt  = mem_type;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    if_valid_nxt  = 1'b0;
    d_rdata_nxt   = d_rdata;
    d_valid_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        unique case (1'b1)
          grant_d: begin
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = d_we;
            mem_type_nxt  = d_type;
            mem_addr_nxt  = d_addr;
            mem_wdata_nxt = d_wdata;
            state_nxt     = DACCESS;
            if (fetch_ok && starve_cnt < SMAX)
              starve_nxt = starve_cnt + 4'd1;
          end
          grant_f: begin
            mem_req_nxt  = 1'b1;
            mem_we_nxt   = 1'b0;
            mem_type_nxt = '0;
            mem_addr_nxt = if_addr;
            starve_nxt   = '0;
            state_nxt    = IFETCH;
          end
          default: ;
        endcase
      end
      DACCESS: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          d_rdata_nxt = mem_rdata;
          d_valid_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      IFETCH: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          state_nxt   = IDLE;
          killed_nxt  = 1'b0;
          if (!killed && !if_kill) begin
            if_rdata_nxt = mem_rdata[INSTR_W-1:0];
            if_valid_nxt = 1'b1;
          end
        end else if (if_kill) begin
          killed_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      killed     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_type   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      if_valid   <= 1'b0;
      d_rdata    <= '0;
      d_valid    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      killed     <= killed_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_type   <= mem_type_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_rdata   <= if_rdata_nxt;
      if_valid   <= if_valid_nxt;
      d_rdata    <= d_rdata_nxt;
      d_valid    <= d_valid_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus, expected events
// queued by the stimulus and consumed by a negedge monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_kill = 1'b0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_type = '0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_rdata;
  logic        d_valid;
  logic        if_stall;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_type;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_type(d_type),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .if_stall(if_stall), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  localparam int EV_GRANT = 0;
  localparam int EV_IV    = 1;
  localparam int EV_DV    = 2;

  typedef struct {
    int          kind;
    logic        we;
    logic [2:0]  typ;
    logic [63:0] addr;
    logic [63:0] data;
    bit          cmp_wdata;
  } ev_t;

  ev_t exq[$];
  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int iv_seen = 0;
  int dv_seen = 0;
  int ack_dly = 0;
  logic [63:0] rd_val = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic we,
                      input logic [2:0] typ, input logic [63:0] a,
                      input logic [63:0] d, input bit cw);
    ev_t e;
    e.kind = k; e.we = we; e.typ = typ;
    e.addr = a; e.data = d; e.cmp_wdata = cw;
    exq.push_back(e);
  endtask

  task automatic handle(input int k);
    ev_t e;
    if (exq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected event: got kind %0d expected none", k);
    end else begin
      e = exq.pop_front();
      chk("event kind", 64'(k), 64'(e.kind));
      if (k == EV_GRANT && e.kind == EV_GRANT) begin
        chk("mem_we", 64'(mem_we), 64'(e.we));
        chk("mem_type", 64'(mem_type), 64'(e.typ));
        chk("mem_addr", mem_addr, e.addr);
        if (e.cmp_wdata) chk("mem_wdata", mem_wdata, e.data);
      end else if (k == EV_IV && e.kind == EV_IV) begin
        chk("if_rdata", 64'(if_rdata), e.data);
      end else if (k == EV_DV && e.kind == EV_DV) begin
        chk("d_rdata", d_rdata, e.data);
      end
    end
  endtask

  // Monitor: one event per cycle at most (grant, fetch or data valid).
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (if_valid && d_valid) overlap++;
        if (mem_req && !prev_req) handle(EV_GRANT);
        if (if_valid) begin iv_seen++; handle(EV_IV); end
        if (d_valid) begin dv_seen++; handle(EV_DV); end
        prev_req = mem_req;
      end else begin
        prev_req = 1'b0;
      end
    end
  end

  // Memory responder: ack ack_dly cycles after mem_req rises.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = rd_val;
      if (mem_req) begin
        mem_ack = (cnt == ack_dly);
        cnt++;
      end else begin
        mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int sel, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      step();
      case (sel)
        0: hit = if_valid;
        1: hit = d_valid;
        2: hit = mem_req;
        default: hit = mem_req && !mem_we;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout %s: got no event expected one", nm);
    end
  endtask

  initial begin
    int n;
    #12;
    chk("rst mem_req", 64'(mem_req), 64'd0);
    chk("rst mem_addr", mem_addr, 64'd0);
    chk("rst mem_wdata", mem_wdata, 64'd0);
    chk("rst valids", 64'({if_valid, d_valid, mem_we}), 64'd0);
    chk("rst rdata", d_rdata | 64'(if_rdata), 64'd0);
    chk("rst starve", 64'(dut.starve_cnt), 64'd0);
    step();
    reset = 1'b1;
    step();

    // single fetch
    ack_dly = 2;
    rd_val = 64'hABCD_1234_0050_0093;
    push(EV_GRANT, 1'b0, 3'd0, 64'h100, 64'd0, 1'b0);
    push(EV_IV, 1'b0, 3'd0, 64'd0, 64'h0050_0093, 1'b0);
    if_req = 1'b1;
    if_addr = 64'h100;
    #1 chk("if_stall waiting", 64'(if_stall), 64'd1);
    wait_for(0, "single fetch");
    chk("if_stall at valid", 64'(if_stall), 64'd0);
    if_req = 1'b0;
    repeat (3) step();

    // conflict: data first, fetch after one bubble
    ack_dly = 1;
    rd_val = 64'hCAFE_0000_0000_0001;
    push(EV_GRANT, 1'b1, 3'd3, 64'h2000, 64'hDEAD_BEEF, 1'b1);
    push(EV_DV, 1'b0, 3'd0, 64'd0, 64'hCAFE_0000_0000_0001, 1'b0);
    push(EV_GRANT, 1'b0, 3'd0, 64'h300, 64'd0, 1'b0);
    push(EV_IV, 1'b0, 3'd0, 64'd0, 64'h13, 1'b0);
    if_req = 1'b1; if_addr = 64'h300;
    d_req = 1'b1; d_we = 1'b1; d_type = 3'd3;
    d_addr = 64'h2000; d_wdata = 64'hDEAD_BEEF;
    #1 chk("d_stall waiting", 64'(d_stall), 64'd1);
    wait_for(1, "conflict data");
    d_req = 1'b0;
    rd_val = 64'h13;
    step();
    chk("fetch after bubble", 64'(mem_req), 64'd1);
    wait_for(0, "conflict fetch");
    if_req = 1'b0;
    repeat (3) step();

    // starvation: four data grants, then fetch
    ack_dly = 0;
    rd_val = 64'h5;
    for (int k = 0; k < 4; k++) begin
      push(EV_GRANT, 1'b1, 3'd2, 64'h3000, 64'h99, 1'b1);
      push(EV_DV, 1'b0, 3'd0, 64'd0, 64'h5, 1'b0);
    end
    push(EV_GRANT, 1'b0, 3'd0, 64'h400, 64'd0, 1'b0);
    push(EV_IV, 1'b0, 3'd0, 64'd0, 64'h5, 1'b0);
    if_req = 1'b1; if_addr = 64'h400;
    d_req = 1'b1; d_we = 1'b1; d_type = 3'd2;
    d_addr = 64'h3000; d_wdata = 64'h99;
    for (int k = 0; k < 4; k++) begin
      wait_for(1, "starve data");
      chk("starve count", 64'(dut.starve_cnt), 64'(k + 1));
    end
    wait_for(3, "starve fetch");
    chk("starve cleared", 64'(dut.starve_cnt), 64'd0);
    d_req = 1'b0;
    wait_for(0, "starve fetch valid");
    if_req = 1'b0;
    repeat (3) step();

    // kill one cycle after grant
    ack_dly = 3;
    push(EV_GRANT, 1'b0, 3'd0, 64'h500, 64'd0, 1'b0);
    if_req = 1'b1; if_addr = 64'h500;
    wait_for(2, "kill grant");
    if_kill = 1'b1; if_req = 1'b0;
    step();
    if_kill = 1'b0;
    n = iv_seen;
    repeat (5) step();
    chk("killed fetch dropped", 64'(iv_seen), 64'(n));
    chk("killed cleared", 64'(dut.killed), 64'd0);

    rd_val = 64'h00A0_0113;
    push(EV_GRANT, 1'b0, 3'd0, 64'h200, 64'd0, 1'b0);
    push(EV_IV, 1'b0, 3'd0, 64'd0, 64'h00A0_0113, 1'b0);
    if_req = 1'b1; if_addr = 64'h200;
    wait_for(0, "fetch after kill");
    if_req = 1'b0;
    repeat (2) step();

    // kill in the ack cycle
    ack_dly = 2;
    push(EV_GRANT, 1'b0, 3'd0, 64'h600, 64'd0, 1'b0);
    if_req = 1'b1; if_addr = 64'h600;
    wait_for(2, "ack-kill grant");
    step();
    step();
    if_kill = 1'b1; if_req = 1'b0;
    step();
    if_kill = 1'b0;
    n = iv_seen;
    repeat (4) step();
    chk("ack-cycle kill dropped", 64'(iv_seen), 64'(n));

    // kill on the request cycle: no grant
    if_req = 1'b1; if_kill = 1'b1; if_addr = 64'h700;
    step();
    chk("kill req no grant", 64'(mem_req), 64'd0);
    if_req = 1'b0; if_kill = 1'b0;
    step();
    chk("kill req still idle", 64'(mem_req), 64'd0);

    // reset in the middle of a data access
    ack_dly = 100;
    push(EV_GRANT, 1'b0, 3'd5, 64'h4000, 64'h77, 1'b1);
    d_req = 1'b1; d_we = 1'b0; d_type = 3'd5;
    d_addr = 64'h4000; d_wdata = 64'h77;
    wait_for(2, "reset grant");
    @(negedge clk);
    #1 reset = 1'b0;
    #1 chk("async rst mem_req", 64'(mem_req), 64'd0);
    chk("async rst mem_addr", mem_addr, 64'd0);
    d_req = 1'b0;
    n = dv_seen;
    step();
    step();
    reset = 1'b1;
    ack_dly = 0;
    repeat (5) step();
    chk("no d_valid after rst", 64'(dv_seen), 64'(n));
    chk("idle after rst", 64'(mem_req), 64'd0);

    for (int i = 0; i < 20 && exq.size() != 0; i++) step();
    chk("queue drained", 64'(exq.size()), 64'd0);
    chk("valid overlap", 64'(overlap), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
